// File: rtl/udp_tx_arb.sv
// Round-robin N-channel UDP/IPv4/Ethernet transmit framer driving an 8-bit AXIS MAC port.
// Builds header, streams payload, pads runts and flags short/long payloads via tuser.
//
// state | meaning
// IDLE  | pick next requesting channel, latch its request fields
// CSUM  | compute IP header checksum
// HDR   | emit 42 header bytes
// PAY   | forward payload bytes from the granted channel
// PAD   | emit zero bytes for short payload and/or runt frame
// DONE  | tlast is loaded, wait for its handshake and bump IP ID
// DRAIN | discard source bytes of the granted channel until s_tlast
module udp_tx_arb #(
  parameter int          NUM_CH    = 4,
  parameter logic [31:0] LOCAL_IP  = 32'hC0A8_006E,
  parameter logic [47:0] LOCAL_MAC = 48'hABCD_1234_5678,
  parameter logic [15:0] LOCAL_SP  = 16'd8080,
  parameter int          MAX_LEN   = 1472
) (
  input  logic                 axi_clk,
  input  logic                 axi_rst,
  input  logic [47:0]          target_mac,
  input  logic [NUM_CH-1:0]    s_req,
  input  logic [NUM_CH*16-1:0] s_len,
  input  logic [NUM_CH*32-1:0] s_dip,
  input  logic [NUM_CH*16-1:0] s_dport,
  output logic [NUM_CH-1:0]    s_ack,
  input  logic [NUM_CH*8-1:0]  s_tdata,
  input  logic [NUM_CH-1:0]    s_tvalid,
  input  logic [NUM_CH-1:0]    s_tlast,
  output logic [NUM_CH-1:0]    s_tready,
  output logic [7:0]           rgmii_tdata,
  output logic                 rgmii_tvalid,
  output logic                 rgmii_tlast,
  output logic                 rgmii_tuser,
  input  logic                 rgmii_tready,
  output logic [15:0]          err_cnt
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CSUM  = 3'd1;
  localparam logic [2:0] S_HDR   = 3'd2;
  localparam logic [2:0] S_PAY   = 3'd3;
  localparam logic [2:0] S_PAD   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;

  logic [2:0]    state;
  logic [CW-1:0] ptr, g_r, gnt_idx;
  logic          gnt_any;
  logic [15:0]   len_r, dport_r, ip_id, csum_r, pay_rem, frame_rem;
  logic [31:0]   dip_r;
  logic [47:0]   mac_r;
  logic [5:0]    hidx;
  logic          bad, drain_pend;

  logic [15:0]   sel_len, sel_dport;
  logic [31:0]   sel_dip;
  logic [7:0]    ch_tdata;
  logic          ch_tvalid, ch_tlast;

  logic          adv;
  logic          pay_err;
  logic [15:0]   tot_len, udp_len;
  logic [335:0]  hdr_vec;
  logic [8:0]    hbit;
  logic [7:0]    hdr_byte;
  logic [31:0]   csum_sum;
  logic [16:0]   fold1;
  logic [15:0]   fold2;

  assign adv = !rgmii_tvalid || rgmii_tready;

  // Grant search: first pass covers ptr..NUM_CH-1, second pass wraps to 0..ptr-1.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    sel_len   = '0;
    sel_dip   = '0;
    sel_dport = '0;
    ch_tdata  = '0;
    ch_tvalid = 1'b0;
    ch_tlast  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!gnt_any && s_req[i] && (CW'(i) >= ptr)) begin
        gnt_any = 1'b1;
        gnt_idx = CW'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!gnt_any && s_req[i]) begin
        gnt_any = 1'b1;
        gnt_idx = CW'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == CW'(i)) begin
        sel_len   = s_len[16*i +: 16];
        sel_dip   = s_dip[32*i +: 32];
        sel_dport = s_dport[16*i +: 16];
      end
      if (g_r == CW'(i)) begin
        ch_tdata  = s_tdata[8*i +: 8];
        ch_tvalid = s_tvalid[i];
        ch_tlast  = s_tlast[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      s_ack[i]    = !axi_rst && (state == S_IDLE) && gnt_any && (gnt_idx == CW'(i));
      s_tready[i] = (g_r == CW'(i)) && (((state == S_PAY) && adv) || (state == S_DRAIN));
    end
  end

  assign tot_len  = len_r + 16'd28;
  assign udp_len  = len_r + 16'd8;
  assign hdr_vec  = {mac_r, LOCAL_MAC, 16'h0800, 16'h4500, tot_len, ip_id, 16'h4000,
                     16'h4011, csum_r, LOCAL_IP, dip_r, LOCAL_SP, dport_r, udp_len, 16'h0000};
  assign hbit     = 9'd328 - {hidx, 3'b000};
  assign hdr_byte = hdr_vec[hbit +: 8];

  assign csum_sum = 32'h4500 + {16'h0, tot_len} + {16'h0, ip_id} + 32'h4000 + 32'h4011
                  + {16'h0, LOCAL_IP[31:16]} + {16'h0, LOCAL_IP[15:0]}
                  + {16'h0, dip_r[31:16]} + {16'h0, dip_r[15:0]};
  assign fold1    = {1'b0, csum_sum[15:0]} + {1'b0, csum_sum[31:16]};
  assign fold2    = fold1[15:0] + {15'h0, fold1[16]};

  // A payload ends wrongly if s_tlast comes early, or is missing on the len-th byte.
  assign pay_err  = (pay_rem != 16'd1) || !ch_tlast;

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state        <= S_IDLE;
      ptr          <= '0;
      g_r          <= '0;
      len_r        <= '0;
      dport_r      <= '0;
      dip_r        <= '0;
      mac_r        <= '0;
      ip_id        <= '0;
      csum_r       <= '0;
      pay_rem      <= '0;
      frame_rem    <= '0;
      hidx         <= '0;
      bad          <= 1'b0;
      drain_pend   <= 1'b0;
      rgmii_tdata  <= '0;
      rgmii_tvalid <= 1'b0;
      rgmii_tlast  <= 1'b0;
      rgmii_tuser  <= 1'b0;
      err_cnt      <= '0;
    end else begin
      if (adv) begin
        rgmii_tvalid <= 1'b0;
        rgmii_tlast  <= 1'b0;
        rgmii_tuser  <= 1'b0;
      end
      case (state)
        S_IDLE: if (gnt_any) begin
          g_r        <= gnt_idx;
          ptr        <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + CW'(1);
          len_r      <= sel_len;
          dip_r      <= sel_dip;
          dport_r    <= sel_dport;
          mac_r      <= target_mac;
          bad        <= 1'b0;
          drain_pend <= 1'b0;
          hidx       <= '0;
          pay_rem    <= sel_len;
          frame_rem  <= (sel_len < 16'd18) ? 16'd60 : sel_len + 16'd42;
          if (sel_len == 16'd0 || sel_len > 16'(MAX_LEN)) begin
            state <= S_DRAIN;
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
          end else begin
            state <= S_CSUM;
          end
        end
        S_CSUM: begin
          csum_r <= ~fold2;
          state  <= S_HDR;
        end
        S_HDR: if (adv) begin
          rgmii_tdata  <= hdr_byte;
          rgmii_tvalid <= 1'b1;
          frame_rem    <= frame_rem - 16'd1;
          hidx         <= hidx + 6'd1;
          if (hidx == 6'd41) state <= S_PAY;
        end
        S_PAY: if (adv && ch_tvalid) begin
          rgmii_tdata  <= ch_tdata;
          rgmii_tvalid <= 1'b1;
          frame_rem    <= frame_rem - 16'd1;
          pay_rem      <= pay_rem - 16'd1;
          if (pay_rem == 16'd1 || ch_tlast) begin
            if (pay_err) begin
              bad <= 1'b1;
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
            if (pay_rem == 16'd1 && !ch_tlast) drain_pend <= 1'b1;
            if (frame_rem == 16'd1) begin
              rgmii_tlast <= 1'b1;
              rgmii_tuser <= pay_err;
              state       <= S_DONE;
            end else begin
              state <= S_PAD;
            end
          end
        end
        S_PAD: if (adv) begin
          rgmii_tdata  <= 8'h00;
          rgmii_tvalid <= 1'b1;
          frame_rem    <= frame_rem - 16'd1;
          if (frame_rem == 16'd1) begin
            rgmii_tlast <= 1'b1;
            rgmii_tuser <= bad;
            state       <= S_DONE;
          end
        end
        S_DONE: if (rgmii_tvalid && rgmii_tready && rgmii_tlast) begin
          ip_id <= ip_id + 16'd1;
          state <= drain_pend ? S_DRAIN : S_IDLE;
        end
        S_DRAIN: if (ch_tvalid && ch_tlast) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_tx_arb.sv
// Directed bench for udp_tx_arb: frame contents, arbitration, backpressure, length errors.
module tb_udp_tx_arb;
  localparam int NCH = 4;

  logic              axi_clk = 1'b0;
  logic              axi_rst = 1'b1;
  logic [47:0]       target_mac = 48'h0011_2233_4455;
  logic [NCH-1:0]    s_req = '0;
  logic [NCH*16-1:0] s_len = '0;
  logic [NCH*32-1:0] s_dip = '0;
  logic [NCH*16-1:0] s_dport = '0;
  logic [NCH-1:0]    s_ack;
  logic [NCH*8-1:0]  s_tdata = '0;
  logic [NCH-1:0]    s_tvalid = '0;
  logic [NCH-1:0]    s_tlast = '0;
  logic [NCH-1:0]    s_tready;
  logic [7:0]        rgmii_tdata;
  logic              rgmii_tvalid, rgmii_tlast, rgmii_tuser;
  logic              rgmii_tready = 1'b1;
  logic [15:0]       err_cnt;

  int total = 0;
  int bad = 0;
  bit tog_mode = 1'b0;

  logic [9:0]  cap_q[$];
  int          ack_q[$];
  int          nframes = 0;
  int          stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [9:0]  prev_val = '0;
  logic [7:0]  pmem [0:3][0:127];

  udp_tx_arb #(.NUM_CH(NCH)) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst), .target_mac(target_mac),
    .s_req(s_req), .s_len(s_len), .s_dip(s_dip), .s_dport(s_dport), .s_ack(s_ack),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .rgmii_tdata(rgmii_tdata), .rgmii_tvalid(rgmii_tvalid), .rgmii_tlast(rgmii_tlast),
    .rgmii_tuser(rgmii_tuser), .rgmii_tready(rgmii_tready), .err_cnt(err_cnt)
  );

  always #5 axi_clk = ~axi_clk;

  initial begin
    forever begin
      @(posedge axi_clk);
      #1;
      if (tog_mode) rgmii_tready = ~rgmii_tready;
      else rgmii_tready = 1'b1;
    end
  end

  // Output monitor: handshakes seen at negedge complete on the following posedge.
  always @(negedge axi_clk) begin
    if (axi_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!rgmii_tvalid || {rgmii_tuser, rgmii_tlast, rgmii_tdata} != prev_val))
        stall_err++;
      prev_stall = rgmii_tvalid && !rgmii_tready;
      prev_val   = {rgmii_tuser, rgmii_tlast, rgmii_tdata};
      if (rgmii_tvalid && rgmii_tready) begin
        cap_q.push_back({rgmii_tuser, rgmii_tlast, rgmii_tdata});
        if (rgmii_tlast) nframes++;
      end
      for (int c = 0; c < NCH; c++) if (s_ack[c]) ack_q.push_back(c);
    end
  end

  function automatic int fstart(input int f);
    int n;
    n = 0;
    if (f == 0) return 0;
    for (int i = 0; i < cap_q.size(); i++) begin
      if (cap_q[i][8]) begin
        n++;
        if (n == f) return i + 1;
      end
    end
    return 0;
  endfunction

  task automatic do_reset();
    axi_rst  = 1'b1;
    s_req    = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    tog_mode = 1'b0;
    repeat (3) @(posedge axi_clk);
    #1 axi_rst = 1'b0;
    cap_q.delete();
    ack_q.delete();
    nframes   = 0;
    stall_err = 0;
  endtask

  task automatic run_ch(input int c, input logic [15:0] len, input logic [31:0] dip,
                        input logic [15:0] dport, input int nsrc, input int last_at,
                        output int sent);
    int t;
    bit hs;
    sent = 0;
    s_len[16*c +: 16]   = len;
    s_dip[32*c +: 32]   = dip;
    s_dport[16*c +: 16] = dport;
    s_req[c] = 1'b1;
    t = 0;
    forever begin
      @(negedge axi_clk);
      if (s_ack[c] || t > 3000) break;
      t++;
    end
    @(posedge axi_clk);
    #1 s_req[c] = 1'b0;
    for (int i = 0; i < nsrc; i++) begin
      s_tdata[8*c +: 8] = pmem[c][i];
      s_tvalid[c] = 1'b1;
      s_tlast[c]  = (i + 1 == last_at);
      hs = 1'b0;
      t  = 0;
      while (!hs && t < 3000) begin
        @(negedge axi_clk);
        hs = s_tready[c];
        t++;
      end
      if (!hs) break;
      @(posedge axi_clk);
      #1 sent++;
    end
    s_tvalid[c] = 1'b0;
    s_tlast[c]  = 1'b0;
  endtask

  task automatic wait_frames(input int n, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      if (nframes >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge axi_clk);
    end
    repeat (2) @(negedge axi_clk);
  endtask

  task automatic test_reset();
    axi_rst = 1'b1;
    s_req   = '1;
    s_len   = {NCH{16'd4}};
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    total++; if (s_ack !== 4'h0) begin bad++; $display("FAIL reset_ack got=%h want=0", s_ack); end
    total++; if (s_tready !== 4'h0) begin bad++; $display("FAIL reset_tready got=%h want=0", s_tready); end
    total++; if ({rgmii_tvalid, rgmii_tlast, rgmii_tuser} !== 3'b000)
      begin bad++; $display("FAIL reset_flags got=%b want=000", {rgmii_tvalid, rgmii_tlast, rgmii_tuser}); end
    total++; if (rgmii_tdata !== 8'h00) begin bad++; $display("FAIL reset_tdata got=%h want=00", rgmii_tdata); end
    total++; if (err_cnt !== 16'h0) begin bad++; $display("FAIL reset_err got=%h want=0", err_cnt); end
    do_reset();
  endtask

  task automatic test_basic();
    logic [335:0] h;
    logic [7:0]   exp [0:59];
    int sent, ntl;
    bit ok;
    h = {48'h0011_2233_4455, 48'hABCD_1234_5678, 16'h0800, 16'h4500, 16'h0020, 16'h0000,
         16'h4000, 16'h4011, 16'hB897, 32'hC0A8_006E, 32'hC0A8_0077, 16'h1F90, 16'h1F90,
         16'h000C, 16'h0000};
    for (int k = 0; k < 42; k++) exp[k] = h[335 - 8*k -: 8];
    exp[42] = 8'hDE; exp[43] = 8'hAD; exp[44] = 8'hBE; exp[45] = 8'hEF;
    for (int k = 46; k < 60; k++) exp[k] = 8'h00;
    pmem[0][0] = 8'hDE; pmem[0][1] = 8'hAD; pmem[0][2] = 8'hBE; pmem[0][3] = 8'hEF;
    do_reset();
    run_ch(0, 16'd4, 32'hC0A8_0077, 16'h1F90, 4, 4, sent);
    wait_frames(1, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_done frames=%0d want=1", nframes); end
    total++; if (cap_q.size() != 60) begin bad++; $display("FAIL basic_len got=%0d want=60", cap_q.size()); end
    ntl = 0;
    for (int k = 0; k < cap_q.size(); k++) if (cap_q[k][8]) ntl++;
    total++; if (ntl != 1 || cap_q[59][8] !== 1'b1)
      begin bad++; $display("FAIL basic_tlast count=%0d last=%b want=1/1", ntl, cap_q[59][8]); end
    total++; if (cap_q[59][9] !== 1'b0) begin bad++; $display("FAIL basic_tuser got=%b want=0", cap_q[59][9]); end
    for (int k = 0; k < 60; k++) begin
      total++;
      if (cap_q[k][7:0] !== exp[k]) begin bad++; $display("FAIL basic_byte%0d got=%h want=%h", k, cap_q[k][7:0], exp[k]); end
    end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL basic_err got=%0d want=0", err_cnt); end
  endtask

  task automatic test_round_robin();
    int s1, s3, s1b, f1, f2;
    bit ok;
    do_reset();
    fork
      begin
        run_ch(1, 16'd4, 32'hC0A8_0001, 16'd100, 4, 4, s1);
        for (int t = 0; t < 3000 && ack_q.size() < 2; t++) @(negedge axi_clk);
        repeat (10) @(negedge axi_clk);
        run_ch(1, 16'd4, 32'hC0A8_0001, 16'd100, 4, 4, s1b);
      end
      run_ch(3, 16'd4, 32'hC0A8_0003, 16'd300, 4, 4, s3);
    join
    wait_frames(3, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rr_done frames=%0d want=3", nframes); end
    total++; if (ack_q.size() != 3) begin bad++; $display("FAIL rr_acks got=%0d want=3", ack_q.size()); end
    else begin
      total++; if (ack_q[0] != 1 || ack_q[1] != 3 || ack_q[2] != 1)
        begin bad++; $display("FAIL rr_order got=%0d,%0d,%0d want=1,3,1", ack_q[0], ack_q[1], ack_q[2]); end
    end
    f1 = fstart(1);
    f2 = fstart(2);
    total++; if ({cap_q[18][7:0], cap_q[19][7:0]} !== 16'h0000)
      begin bad++; $display("FAIL rr_id0 got=%h want=0000", {cap_q[18][7:0], cap_q[19][7:0]}); end
    total++; if ({cap_q[f1+18][7:0], cap_q[f1+19][7:0]} !== 16'h0001)
      begin bad++; $display("FAIL rr_id_ch3 got=%h want=0001", {cap_q[f1+18][7:0], cap_q[f1+19][7:0]}); end
    total++; if ({cap_q[f1+36][7:0], cap_q[f1+37][7:0]} !== 16'd300)
      begin bad++; $display("FAIL rr_dport_ch3 got=%h want=012c", {cap_q[f1+36][7:0], cap_q[f1+37][7:0]}); end
    total++; if ({cap_q[f2+18][7:0], cap_q[f2+19][7:0]} !== 16'h0002)
      begin bad++; $display("FAIL rr_id_ch1b got=%h want=0002", {cap_q[f2+18][7:0], cap_q[f2+19][7:0]}); end
  endtask

  task automatic test_backpressure();
    int sent, nb;
    bit ok;
    for (int i = 0; i < 128; i++) pmem[2][i] = 8'(i * 7 + 7);
    do_reset();
    tog_mode = 1'b1;
    run_ch(2, 16'd100, 32'hC0A8_0022, 16'd5000, 100, 100, sent);
    wait_frames(1, ok);
    tog_mode = 1'b0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_done frames=%0d want=1", nframes); end
    total++; if (cap_q.size() != 142) begin bad++; $display("FAIL bp_len got=%0d want=142", cap_q.size()); end
    total++; if (stall_err != 0) begin bad++; $display("FAIL bp_stable violations=%0d want=0", stall_err); end
    nb = 0;
    for (int k = 0; k < 100; k++) if (cap_q[42+k][7:0] !== pmem[2][k]) nb++;
    total++; if (nb != 0) begin bad++; $display("FAIL bp_payload wrong_bytes=%0d want=0", nb); end
    total++; if (cap_q[141][9:8] !== 2'b01) begin bad++; $display("FAIL bp_end user/last=%b want=01", cap_q[141][9:8]); end
  endtask

  task automatic test_early_tlast();
    int sent;
    bit ok;
    for (int i = 0; i < 128; i++) pmem[1][i] = 8'(i * 7 + 4);
    do_reset();
    run_ch(1, 16'd8, 32'hC0A8_0011, 16'd7, 5, 5, sent);
    wait_frames(1, ok);
    total++; if (ok !== 1'b1 || sent != 5) begin bad++; $display("FAIL early_done frames=%0d sent=%0d want=1/5", nframes, sent); end
    total++; if (cap_q.size() != 60) begin bad++; $display("FAIL early_len got=%0d want=60", cap_q.size()); end
    total++; if ({cap_q[16][7:0], cap_q[17][7:0]} !== 16'h0024)
      begin bad++; $display("FAIL early_totlen got=%h want=0024", {cap_q[16][7:0], cap_q[17][7:0]}); end
    total++; if ({cap_q[42][7:0], cap_q[46][7:0]} !== {pmem[1][0], pmem[1][4]})
      begin bad++; $display("FAIL early_payload got=%h want=%h", {cap_q[42][7:0], cap_q[46][7:0]}, {pmem[1][0], pmem[1][4]}); end
    for (int k = 47; k < 60; k++) begin
      total++;
      if (cap_q[k][7:0] !== 8'h00) begin bad++; $display("FAIL early_zero%0d got=%h want=00", k, cap_q[k][7:0]); end
    end
    total++; if (cap_q[59][9:8] !== 2'b11) begin bad++; $display("FAIL early_end user/last=%b want=11", cap_q[59][9:8]); end
    total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL early_err got=%0d want=1", err_cnt); end
  endtask

  task automatic test_late_tlast();
    int sent, ntl;
    bit ok;
    for (int i = 0; i < 128; i++) pmem[3][i] = 8'(i + 8'h30);
    do_reset();
    run_ch(3, 16'd20, 32'hC0A8_0033, 16'd9, 25, 25, sent);
    wait_frames(1, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL late_done frames=%0d want=1", nframes); end
    total++; if (sent != 25) begin bad++; $display("FAIL late_drain sent=%0d want=25", sent); end
    total++; if (cap_q.size() != 62) begin bad++; $display("FAIL late_len got=%0d want=62", cap_q.size()); end
    ntl = 0;
    for (int k = 0; k < cap_q.size(); k++) if (cap_q[k][8]) ntl++;
    total++; if (ntl != 1 || cap_q[61][9:8] !== 2'b11)
      begin bad++; $display("FAIL late_end tlasts=%0d user/last=%b want=1/11", ntl, cap_q[61][9:8]); end
    total++; if (cap_q[61][7:0] !== pmem[3][19]) begin bad++; $display("FAIL late_lastbyte got=%h want=%h", cap_q[61][7:0], pmem[3][19]); end
    total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL late_err got=%0d want=1", err_cnt); end
  endtask

  task automatic test_reject();
    int s0, s1, s2;
    bit ok;
    for (int i = 0; i < 128; i++) pmem[0][i] = 8'(i + 1);
    do_reset();
    run_ch(0, 16'd0, 32'hC0A8_0077, 16'd1, 3, 3, s0);
    run_ch(0, 16'd1473, 32'hC0A8_0077, 16'd1, 2, 2, s1);
    repeat (5) @(negedge axi_clk);
    total++; if (s0 != 3 || s1 != 2) begin bad++; $display("FAIL rej_drain sent=%0d,%0d want=3,2", s0, s1); end
    total++; if (nframes != 0 || cap_q.size() != 0) begin bad++; $display("FAIL rej_noframe bytes=%0d want=0", cap_q.size()); end
    total++; if (ack_q.size() != 2) begin bad++; $display("FAIL rej_acks got=%0d want=2", ack_q.size()); end
    total++; if (err_cnt !== 16'd2) begin bad++; $display("FAIL rej_err got=%0d want=2", err_cnt); end
    run_ch(0, 16'd4, 32'hC0A8_0077, 16'd1, 4, 4, s2);
    wait_frames(1, ok);
    total++; if (ok !== 1'b1 || cap_q.size() != 60) begin bad++; $display("FAIL rej_next bytes=%0d want=60", cap_q.size()); end
    total++; if ({cap_q[18][7:0], cap_q[19][7:0]} !== 16'h0000)
      begin bad++; $display("FAIL rej_id got=%h want=0000", {cap_q[18][7:0], cap_q[19][7:0]}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_early_tlast();
    test_late_tlast();
    test_reject();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/udp_tx_arb.md
Name: udp_tx_arb

Overview:
N-channel UDP transmit framer. Each channel issues a send request (length, destination IP, destination port) and then streams its payload bytes. The block picks one requesting channel by round-robin and builds a complete Ethernet/IPv4/UDP frame on the 8-bit AXIS stream toward the RGMII MAC. It computes the IP header checksum, pads runt frames and flags length mismatches. It replaces the single-channel transmit path under the Ethernet top level.

Parameters:
NUM_CH, 4, number of source channels (1..8)
LOCAL_IP, 32'hC0A8_006E, source IP address
LOCAL_MAC, 48'hABCD_1234_5678, source MAC address
LOCAL_SP, 16'd8080, UDP source port
MAX_LEN, 1472, largest accepted UDP payload length in bytes

Ports:
axi_clk  in  1  clock
axi_rst  in  1  synchronous reset, active-high
target_mac  in  48  destination MAC; sampled at request accept
s_req  in  NUM_CH  per-channel send request; held until s_ack
s_len  in  NUM_CH*16  per-channel payload length in bytes, channel i at [16i+:16]
s_dip  in  NUM_CH*32  per-channel destination IP
s_dport  in  NUM_CH*16  per-channel UDP destination port
s_ack  out  NUM_CH  one-cycle pulse; request fields are sampled in that cycle
s_tdata  in  NUM_CH*8  per-channel payload byte
s_tvalid  in  NUM_CH  payload valid
s_tlast  in  NUM_CH  last payload byte
s_tready  out  NUM_CH  payload ready
rgmii_tdata  out  8  frame byte
rgmii_tvalid  out  1  frame byte valid
rgmii_tlast  out  1  last frame byte
rgmii_tuser  out  1  bad-frame flag; valid together with tlast
rgmii_tready  in  1  MAC ready
err_cnt  out  16  count of rejected or mismatched frames; saturates at 16'hFFFF

Behaviour:
- Reset values:
  - All outputs are 0.
  - IP ID counter is 0.
  - Round-robin pointer is 0, so channel 0 has highest priority after reset.
  - State is IDLE.
  - A reset during a frame truncates the frame at the next edge; no tlast is emitted.
- States: IDLE -> CSUM -> HDR -> PAY -> PAD -> IDLE; DRAIN is entered on reject or overrun.
- IDLE:
  - If any s_req is set, grant the first requesting channel at or after the pointer (wrapping).
  - Pulse s_ack[g] and latch len, dip, dport and target_mac.
  - Set the pointer to g+1 mod NUM_CH.
  - If len==0 or len>MAX_LEN, go to DRAIN and increment err_cnt. Otherwise go to CSUM.
- CSUM (1 cycle): compute the IP header checksum.
  - Header words with checksum field 0: 4500, 28+len, ID, 4000, 4011, 0000, srcIP hi/lo, dstIP hi/lo.
  - Form the 32-bit sum, fold carries twice, then invert.
- HDR emits 42 bytes, MSB-first:
  - target_mac, LOCAL_MAC, 0800
  - 45, 00, total length = 28+len, ID, 40 00, TTL 40, proto 11, checksum, LOCAL_IP, dip
  - LOCAL_SP, dport, UDP length = 8+len, UDP checksum 0000
- Output register rules:
  - The output register advances when !rgmii_tvalid || rgmii_tready.
  - Data, last and user stay stable while tvalid=1 and tready=0.
  - tvalid stays continuously high from the first header byte to tlast, provided the source streams without gaps.
- PAY:
  - s_tready[g] = (!rgmii_tvalid || rgmii_tready). All other channels see s_tready=0.
  - The byte counter counts accepted payload bytes.
- Early s_tlast (before len bytes): fill the remaining len bytes with 00 via PAD, set tuser=1 on tlast, increment err_cnt.
- Late tlast (len-th byte has no s_tlast):
  - End the frame normally at len bytes, with tuser=1 on tlast.
  - Increment err_cnt.
  - Go to DRAIN: s_tready[g]=1 and bytes are discarded until s_tlast.
- Runt padding: if 42+len<60, PAD appends 00 bytes until the frame is 60 bytes. tlast goes on byte 60.
- IP ID increments by 1 after every emitted frame and wraps at 16'hFFFF. Rejected requests do not consume an ID.
- New requests are evaluated only in IDLE, one cycle after the previous frame's tlast handshake.
- Simultaneous request and tlast: a request raised in the cycle of the tlast handshake is served from IDLE on the next cycle.

Test Plan:
- ch0 request, len=4, dip=C0A80077, dport=1F90, payload DE AD BE EF, tready=1:
  - 60-byte frame; bytes 14..15 = 45 00; total length 0020; ID 0000; checksum B897; UDP length 000C.
  - Bytes 42..45 = DEADBEEF; 14 zero pad bytes; tuser=0; tlast only on byte 60.
- ch1 and ch3 request together after reset:
  - ch1 served first, then ch3.
  - A new ch1 request raised during ch3's frame is served after ch3; the ch3 frame carries ID 0001.
- len=100, tready toggling 1/0 every cycle:
  - 142 bytes out, each byte held stable while tready=0; no bytes lost or duplicated.
- len=8 with s_tlast on byte 5:
  - Bytes 5..7 of the payload are 00, then padding; tuser=1 on byte 60; err_cnt=1.
- len=20 with s_tlast on byte 25:
  - Frame is 62 bytes with tuser=1; the next 5 source bytes are drained; err_cnt increments.
- len=0, then len=1473:
  - No frame output; s_ack pulses; the channel drains to tlast; err_cnt=2; the next valid frame uses ID 0000.
